// File: rtl/count_display_mux.sv
// count_display_mux: scans up/down counts onto a shared 7-segment bus and blinks on Swap rising edges
module count_display_mux #(
  parameter int REFRESH_DIV   = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] UpCountS,
  input  logic [3:0] DownCountS,
  input  logic       Swap,
  output logic [6:0] Segments,
  output logic [1:0] DigitSel,
  output logic       Blinking
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_PERIODS + 1);
  // Patterns for F down to 0, so value v sits at bits [v*7 +: 7]
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  typedef enum logic {UP, DOWN} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    digit;
  logic          swap_q, tick, swap_edge;
  assign tick      = presc_q == PW'(REFRESH_DIV - 1);
  assign swap_edge = Swap & ~swap_q;
  assign digit     = state_q == UP ? UpCountS : DownCountS;
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = tick ? (state_q == UP ? DOWN : UP) : state_q;
    seg_d   = tick ? HEX[digit*7 +: 7] : seg_q;
    sel_d   = !tick ? sel_q : blink_q[0] ? 2'b00 : state_q == UP ? 2'b01 : 2'b10;
    blink_d = swap_edge ? BW'(BLINK_PERIODS) : (tick && blink_q != '0) ? blink_q - 1'b1 : blink_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc_q <= '0;
      state_q <= UP;
      blink_q <= '0;
      swap_q  <= 1'b0;
      seg_q   <= '0;
      sel_q   <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      blink_q <= blink_d;
      swap_q  <= Swap;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end
  assign Segments = seg_q;
  assign DigitSel = sel_q;
  assign Blinking = blink_q != '0;
endmodule

// File: tb/tb_count_display_mux.sv
// tb_count_display_mux: directed checks of scan, latency, mid-period sampling, blink and reset
module tb_count_display_mux;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] UpCountS = 4'h3;
  logic [3:0] DownCountS = 4'hC;
  logic       Swap = 1'b0;
  logic [6:0] Segments;
  logic [1:0] DigitSel;
  logic       Blinking;
  int checks = 0;
  int passes = 0;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  count_display_mux #(.REFRESH_DIV(4), .BLINK_PERIODS(4)) dut (
    .Clock(Clock), .Reset(Reset), .UpCountS(UpCountS), .DownCountS(DownCountS),
    .Swap(Swap), .Segments(Segments), .DigitSel(DigitSel), .Blinking(Blinking)
  );

  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    step(3);
    checks++;
    if ({Segments, DigitSel, Blinking} !== 10'b0)
      $display("FAIL reset_hold: got seg=%h sel=%b blink=%b want 00/00/0", Segments, DigitSel, Blinking);
    else passes++;
    Reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++;
      if ({Segments, DigitSel, Blinking} !== 10'b0)
        $display("FAIL reset_latency edge %0d: got seg=%h sel=%b want 00/00", i, Segments, DigitSel);
      else passes++;
    end
    step(1);
    checks++;
    if ({Segments, DigitSel, Blinking} !== {7'h4F, 2'b01, 1'b0})
      $display("FAIL first_update: got seg=%h sel=%b blink=%b want 4f/01/0", Segments, DigitSel, Blinking);
    else passes++;
  endtask

  task automatic test_scan;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({Segments, DigitSel} !== (p[0] ? {7'h39, 2'b10} : {7'h4F, 2'b01}))
          $display("FAIL scan p%0d c%0d: got seg=%h sel=%b want %s", p, c, Segments, DigitSel,
                   p[0] ? "39/10" : "4f/01");
        else passes++;
        step(1);
      end
    end
  endtask

  task automatic test_mid_change;
    step(2);
    UpCountS = 4'h5;
    for (int c = 2; c < 4; c++) begin
      checks++;
      if ({Segments, DigitSel} !== {7'h4F, 2'b01})
        $display("FAIL mid_change_hold c%0d: got seg=%h sel=%b want 4f/01", c, Segments, DigitSel);
      else passes++;
      step(1);
    end
    step(4);
    checks++;
    if ({Segments, DigitSel} !== {7'h6D, 2'b01})
      $display("FAIL mid_change_next: got seg=%h sel=%b want 6d/01", Segments, DigitSel);
    else passes++;
    UpCountS = 4'h3;
    step(8);
    checks++;
    if ({Segments, DigitSel} !== {7'h4F, 2'b01})
      $display("FAIL mid_change_restore: got seg=%h sel=%b want 4f/01", Segments, DigitSel);
    else passes++;
  endtask

  task automatic test_blink;
    step(2);
    Swap = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (i == 1 || i == 13) begin
        checks++;
        if (Blinking !== 1'b1) $display("FAIL blink_active i%0d: got %b want 1", i, Blinking);
        else passes++;
      end
      if (i == 2 || i == 6 || i == 10 || i == 14) begin
        checks++;
        if ({Segments, DigitSel, Blinking} !==
            (i == 2  ? {7'h39, 2'b10, 1'b1} :
             i == 6  ? {7'h4F, 2'b00, 1'b1} :
             i == 10 ? {7'h39, 2'b10, 1'b1} : {7'h4F, 2'b00, 1'b0}))
          $display("FAIL blink_tick i%0d: got seg=%h sel=%b blink=%b", i, Segments, DigitSel, Blinking);
        else passes++;
      end
    end
    Swap = 1'b0;
    checks++;
    if (Blinking !== 1'b0) $display("FAIL blink_single_edge: got %b want 0", Blinking);
    else passes++;
    step(3);
    checks++;
    if ({Segments, DigitSel, Blinking} !== {7'h39, 2'b10, 1'b0})
      $display("FAIL blink_done: got seg=%h sel=%b blink=%b want 39/10/0", Segments, DigitSel, Blinking);
    else passes++;
  endtask

  task automatic test_coincident;
    Swap = 1'b1;
    step(1);
    Swap = 1'b0;
    checks++;
    if (Blinking !== 1'b1) $display("FAIL coin_start: got %b want 1", Blinking);
    else passes++;
    step(3);
    checks++;
    if ({Segments, DigitSel} !== {7'h4F, 2'b01})
      $display("FAIL coin_t1: got seg=%h sel=%b want 4f/01", Segments, DigitSel);
    else passes++;
    step(4);
    checks++;
    if ({Segments, DigitSel} !== {7'h39, 2'b00})
      $display("FAIL coin_t2: got seg=%h sel=%b want 39/00", Segments, DigitSel);
    else passes++;
    step(4);
    step(3);
    Swap = 1'b1;
    step(1);
    Swap = 1'b0;
    checks++;
    if ({Segments, DigitSel, Blinking} !== {7'h39, 2'b00, 1'b1})
      $display("FAIL coin_tick: got seg=%h sel=%b blink=%b want 39/00/1", Segments, DigitSel, Blinking);
    else passes++;
    step(4);
    checks++;
    if ({Segments, DigitSel, Blinking} !== {7'h4F, 2'b01, 1'b1})
      $display("FAIL coin_reload: got seg=%h sel=%b blink=%b want 4f/01/1", Segments, DigitSel, Blinking);
    else passes++;
  endtask

  task automatic test_reset_mid_blink;
    step(2);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    checks++;
    if ({Segments, DigitSel, Blinking} !== 10'b0)
      $display("FAIL rst_mid: got seg=%h sel=%b blink=%b want 00/00/0", Segments, DigitSel, Blinking);
    else passes++;
    step(3);
    checks++;
    if ({Segments, DigitSel, Blinking} !== 10'b0)
      $display("FAIL rst_mid_wait: got seg=%h sel=%b blink=%b want 00/00/0", Segments, DigitSel, Blinking);
    else passes++;
    step(1);
    checks++;
    if ({Segments, DigitSel, Blinking} !== {7'h4F, 2'b01, 1'b0})
      $display("FAIL rst_mid_first: got seg=%h sel=%b blink=%b want 4f/01/0", Segments, DigitSel, Blinking);
    else passes++;
    step(4);
    checks++;
    if ({Segments, DigitSel} !== {7'h39, 2'b10})
      $display("FAIL rst_mid_second: got seg=%h sel=%b want 39/10", Segments, DigitSel);
    else passes++;
  endtask

  task automatic test_hex;
    for (int v = 0; v < 16; v++) begin
      UpCountS = v[3:0];
      DownCountS = 4'(15 - v);
      step(4);
      checks++;
      if ({Segments, DigitSel} !== {hex_tab[v], 2'b01})
        $display("FAIL hex_up %0d: got seg=%h sel=%b want %h/01", v, Segments, DigitSel, hex_tab[v]);
      else passes++;
      step(4);
      checks++;
      if ({Segments, DigitSel} !== {hex_tab[15 - v], 2'b10})
        $display("FAIL hex_down %0d: got seg=%h sel=%b want %h/10", 15 - v, Segments, DigitSel, hex_tab[15 - v]);
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_mid_change;
    test_blink;
    test_coincident;
    test_reset_mid_blink;
    test_hex;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
